// File: rtl/commit_pkg.sv
// Shared definitions for the commit/writeback stage: writeback source select codes
// and the fixed instruction word width.
package commit_pkg;

    typedef enum logic [1:0] {
        SEL_ALU = 2'd0,
        SEL_MEM = 2'd1,
        SEL_PC4 = 2'd2,
        SEL_RSV = 2'd3
    } wsel_e;

    localparam int INST_W = 32;

endpackage

// File: rtl/commit_fifo.sv
// Generic in-order DEPTH x W queue with push/pop/flush. Pointers carry one extra
// wrap bit so full and empty can be told apart without a separate counter.
module commit_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush) begin
            // Dropping everything is just catching the read pointer up.
            rd_ptr_reg <= wr_ptr_reg;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr_reg[AW-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr_reg[AW-1:0]];
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

endmodule

// File: rtl/commit_queue.sv
// Commit/writeback stage: resolves the writeback mux at enqueue, queues entries in
// order and retires at most one per cycle into registered GPR/CSR strobes and trace.
module commit_queue
    import commit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2,
    parameter int RADDR_W    = 5,
    parameter int CSR_ADDR_W = 12
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      flush_i,
    input  logic                      retire_en_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic [XLEN-1:0]           pc_i,
    input  logic [INST_W-1:0]         inst_i,
    input  logic [1:0]                wsel_i,
    input  logic                      wena_i,
    input  logic [RADDR_W-1:0]        waddr_i,
    input  logic [XLEN-1:0]           alu_result_i,
    input  logic [XLEN-1:0]           mem_result_i,
    input  logic                      csr_wena_i,
    input  logic [CSR_ADDR_W-1:0]     csr_waddr_i,
    input  logic [XLEN-1:0]           csr_wdata_i,
    output logic                      wena_o,
    output logic [RADDR_W-1:0]        waddr_o,
    output logic [XLEN-1:0]           wdata_o,
    output logic                      csr_wena_o,
    output logic [CSR_ADDR_W-1:0]     csr_waddr_o,
    output logic [XLEN-1:0]           csr_wdata_o,
    output logic                      commit_o,
    output logic [XLEN-1:0]           commit_pc_o,
    output logic [INST_W-1:0]         commit_inst_o,
    output logic [$clog2(DEPTH):0]    count_o,
    output logic [63:0]               instret_o
);
    typedef struct packed {
        logic [XLEN-1:0]       pc;
        logic [INST_W-1:0]     inst;
        logic                  wena;
        logic [RADDR_W-1:0]    waddr;
        logic [XLEN-1:0]       wdata;
        logic                  csr_wena;
        logic [CSR_ADDR_W-1:0] csr_waddr;
        logic [XLEN-1:0]       csr_wdata;
    } entry_t;

    entry_t          in_entry;
    entry_t          head_entry;
    logic [XLEN-1:0] wdata_sel;
    logic            fifo_full;
    logic            fifo_empty;
    logic            push;
    logic            pop;

    logic                  wena_reg;
    logic [RADDR_W-1:0]    waddr_reg;
    logic [XLEN-1:0]       wdata_reg;
    logic                  csr_wena_reg;
    logic [CSR_ADDR_W-1:0] csr_waddr_reg;
    logic [XLEN-1:0]       csr_wdata_reg;
    logic                  commit_reg;
    logic [XLEN-1:0]       commit_pc_reg;
    logic [INST_W-1:0]     commit_inst_reg;
    logic [63:0]           instret_reg;

    // A retiring head frees a slot, so a full queue still accepts in the same cycle.
    assign pop        = retire_en_i && !fifo_empty && !flush_i;
    assign in_ready_o = !fifo_full || pop;
    assign push       = in_valid_i && in_ready_o && !flush_i;

    always_comb begin
        wdata_sel = alu_result_i;
        case (wsel_e'(wsel_i))
            SEL_MEM: wdata_sel = mem_result_i;
            SEL_PC4: wdata_sel = pc_i + XLEN'(4);
            default: wdata_sel = alu_result_i;
        endcase
    end

    always_comb begin
        in_entry           = '0;
        in_entry.pc        = pc_i;
        in_entry.inst      = inst_i;
        in_entry.wena      = wena_i;
        in_entry.waddr     = waddr_i;
        in_entry.wdata     = wdata_sel;
        in_entry.csr_wena  = csr_wena_i;
        in_entry.csr_waddr = csr_waddr_i;
        in_entry.csr_wdata = csr_wdata_i;
    end

    commit_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .flush (flush_i),
        .push  (push),
        .pop   (pop),
        .wdata (in_entry),
        .rdata (head_entry),
        .count (count_o),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wena_reg        <= 1'b0;
            waddr_reg       <= '0;
            wdata_reg       <= '0;
            csr_wena_reg    <= 1'b0;
            csr_waddr_reg   <= '0;
            csr_wdata_reg   <= '0;
            commit_reg      <= 1'b0;
            commit_pc_reg   <= '0;
            commit_inst_reg <= '0;
            instret_reg     <= '0;
        end else begin
            wena_reg     <= 1'b0;
            csr_wena_reg <= 1'b0;
            commit_reg   <= 1'b0;
            if (pop) begin
                // Writes to x0 still retire; only the register-file strobe is masked.
                wena_reg        <= head_entry.wena && (head_entry.waddr != '0);
                waddr_reg       <= head_entry.waddr;
                wdata_reg       <= head_entry.wdata;
                csr_wena_reg    <= head_entry.csr_wena;
                csr_waddr_reg   <= head_entry.csr_waddr;
                csr_wdata_reg   <= head_entry.csr_wdata;
                commit_reg      <= 1'b1;
                commit_pc_reg   <= head_entry.pc;
                commit_inst_reg <= head_entry.inst;
                instret_reg     <= instret_reg + 64'd1;
            end
        end
    end

    assign wena_o        = wena_reg;
    assign waddr_o       = waddr_reg;
    assign wdata_o       = wdata_reg;
    assign csr_wena_o    = csr_wena_reg;
    assign csr_waddr_o   = csr_waddr_reg;
    assign csr_wdata_o   = csr_wdata_reg;
    assign commit_o      = commit_reg;
    assign commit_pc_o   = commit_pc_reg;
    assign commit_inst_o = commit_inst_reg;
    assign instret_o     = instret_reg;

endmodule
